// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared encodings for the multicycle RV32I controller
package riscv_mc_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
   } state_t;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_FN  = 2'b10;
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;
   // Immediate format implied by the opcode; unknown opcodes fall back to I-type.
   function automatic logic [1:0] imm_src(input logic [6:0] op);
      return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
   endfunction
endpackage

// File: rtl/aludec.sv
// aludec: ALU operation decode from ALUOp and the instruction funct fields
module aludec
   import riscv_mc_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] alu_op,
   output logic [2:0] alu_control
);
   // Only R-type (op5=1) with funct7b5 turns funct3=000 into a subtract.
   always_comb
      alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                    alu_op == ALUOP_SUB ? ALU_SUB :
                    funct3 == 3'b000    ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                    funct3 == 3'b010    ? ALU_SLT :
                    funct3 == 3'b110    ? ALU_OR  :
                    funct3 == 3'b111    ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/mc_fsm.sv
// mc_fsm: state register, next-state logic and Moore outputs of the multicycle controller
module mc_fsm
   import riscv_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       adr_src,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       branch,
   output logic       pc_update,
   output logic       illegal_op,
   output logic       instr_retire
);
   state_t state, state_next;
   // State register; reset returns to FETCH at once, abandoning any instruction in flight.
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= FETCH;
      else state <= state_next;
   // Next state and per-state outputs; all write enables are suppressed while reset is high.
   always_comb begin
      state_next   = state;
      adr_src      = 1'b0;
      ir_write     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      result_src   = RES_ALUOUT;
      alu_src_a    = SRCA_PC;
      alu_src_b    = SRCB_RS2;
      alu_op       = ALUOP_ADD;
      branch       = 1'b0;
      pc_update    = 1'b0;
      illegal_op   = 1'b0;
      instr_retire = 1'b0;
      case (state)
         FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = mem_ready;
            pc_update  = mem_ready;
            state_next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECUTER;
               OP_I:         state_next = EXECUTEI;
               OP_JAL:       state_next = JAL;
               OP_BEQ:       state_next = BEQ;
               default: begin
                  state_next = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            state_next = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src    = 1'b1;
            state_next = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src   = RES_DATA;
            reg_write    = 1'b1;
            instr_retire = 1'b1;
            state_next   = FETCH;
         end
         MEMWRITE: begin
            adr_src      = 1'b1;
            mem_write    = 1'b1;
            instr_retire = mem_ready;
            state_next   = mem_ready ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_FN;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FN;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write    = 1'b1;
            instr_retire = 1'b1;
            state_next   = FETCH;
         end
         BEQ: begin
            alu_src_a    = SRCA_RS1;
            alu_op       = ALUOP_SUB;
            branch       = 1'b1;
            instr_retire = 1'b1;
            state_next   = FETCH;
         end
         JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_update  = 1'b1;
            state_next = ALUWB;
         end
         default: state_next = FETCH;
      endcase
      if (reset) begin
         ir_write     = 1'b0;
         mem_write    = 1'b0;
         reg_write    = 1'b0;
         branch       = 1'b0;
         pc_update    = 1'b0;
         illegal_op   = 1'b0;
         instr_retire = 1'b0;
      end
   end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control path of the multicycle RV32I datapath (optional MC_MEM_READY_EN adds a memory handshake)
module multicycle_controller
   import riscv_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
`ifdef MC_MEM_READY_EN
   input  logic       mem_ready,
`endif
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       illegal_op,
   output logic       instr_retire
);
   logic [1:0] alu_op;
   logic       branch, pc_update, ready;
`ifdef MC_MEM_READY_EN
   assign ready = mem_ready;
`else
   assign ready = 1'b1;
`endif
   mc_fsm u_fsm (
      .clk(clk), .reset(reset), .op(op), .mem_ready(ready),
      .adr_src(AdrSrc), .ir_write(IRWrite), .mem_write(MemWrite), .reg_write(RegWrite),
      .result_src(ResultSrc), .alu_src_a(ALUSrcA), .alu_src_b(ALUSrcB), .alu_op(alu_op),
      .branch(branch), .pc_update(pc_update), .illegal_op(illegal_op), .instr_retire(instr_retire)
   );
   aludec u_aludec (
      .op5(op[5]), .funct3(funct3), .funct7b5(funct7b5), .alu_op(alu_op), .alu_control(ALUControl)
   );
   // Branch resolution uses the Zero flag of the same cycle, so PC update is combinational.
   always_comb begin
      PCWrite = (branch & Zero) | pc_update;
      ImmSrc  = imm_src(op);
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized cycle-by-cycle check against an instruction-level model
module tb_multicycle_controller;
   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
   logic       clk = 1'b0, reset = 1'b1;
   logic [6:0] op = LW;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b1;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op, instr_retire;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   int         n_vec = 0, n_err = 0;
   logic [17:0] obs;
   always #5 clk = ~clk;
   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
`ifdef MC_MEM_READY_EN
      .mem_ready(mem_ready),
`endif
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_op(illegal_op), .instr_retire(instr_retire)
   );
   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 RegWrite, ImmSrc, ALUControl, illegal_op, instr_retire};
   function automatic bit legal(input logic [6:0] o);
      return o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ;
   endfunction
   function automatic int cycles(input logic [6:0] o);
      return o == LW ? 5 : o == BQ ? 3 : legal(o) ? 4 : 2;
   endfunction
   // Expected outputs for cycle k (0 = fetch) of an instruction, from the instruction-level rules.
   function automatic logic [17:0] model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                         input logic z, input int k, input logic rst, input logic rdy);
      logic       pcw, adr, mw, irw, rw, ill, ret;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu, fn;
      {pcw, adr, mw, irw, rw, ill, ret} = '0;
      rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
      imm = o == SW ? 2'd1 : o == BQ ? 2'd2 : o == JL ? 2'd3 : 2'd0;
      fn = f3 == 3'd0 ? ((o[5] & f7) ? 3'd1 : 3'd0) : f3 == 3'd2 ? 3'd5 : f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd2 : 3'd0;
      if (k == 0) begin
         irw = rdy; pcw = rdy; sb = 2'd2; rs = 2'd2;
      end else if (k == 1) begin
         sa = 2'd1; sb = 2'd1; ill = !legal(o);
      end else if (o == LW || o == SW) begin
         if (k == 2) begin sa = 2'd2; sb = 2'd1; end
         else if (o == SW) begin adr = 1'b1; mw = 1'b1; ret = 1'b1; end
         else if (k == 3) adr = 1'b1;
         else begin rs = 2'd1; rw = 1'b1; ret = 1'b1; end
      end else if (o == BQ) begin
         sa = 2'd2; alu = 3'd1; pcw = z; ret = 1'b1;
      end else if (k == 2) begin
         if (o == JL) begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; end
         else begin sa = 2'd2; sb = o == IT ? 2'd1 : 2'd0; alu = fn; end
      end else begin
         rw = 1'b1; ret = 1'b1;
      end
      if (rst) {pcw, mw, irw, rw, ill, ret} = '0;
      return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill, ret};
   endfunction
   task automatic check(input string tag, input logic [17:0] want);
      @(negedge clk);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
   endtask
   // Runs cycles k0..k1 of one instruction; zsel 0/1 forces Zero, 2 randomizes it each cycle.
   task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input int zsel, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         op = o; funct3 = f3; funct7b5 = f7;
         Zero = zsel == 2 ? 1'($urandom) : 1'(zsel);
         check($sformatf("%s k%0d", tag, k), model(o, f3, f7, Zero, k, 1'b0, 1'b1));
         @(posedge clk); #1;
      end
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [6:0] o;
      logic [2:0] f3s [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
      repeat (2) @(posedge clk);
      #1;
      check("reset", model(LW, 3'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1));
      @(posedge clk); #1;
      reset = 1'b0;
      run("lw", LW, 3'd2, 1'b0, 2, 0, 4);
      run("lw_part", LW, 3'd2, 1'b0, 2, 0, 2);
      reset = 1'b1;
      Zero = 1'b1;
      check("reset_memread", model(LW, 3'd2, 1'b0, 1'b1, 0, 1'b1, 1'b1));
      @(posedge clk); #1;
      reset = 1'b0;
      run("after_reset", SW, 3'd2, 1'b0, 2, 0, 3);
      run("beq_z1", BQ, 3'd0, 1'b0, 1, 0, 2);
      run("beq_z0", BQ, 3'd0, 1'b0, 0, 0, 2);
      run("sub", RT, 3'd0, 1'b1, 2, 0, 3);
      run("addi_f7", IT, 3'd0, 1'b1, 2, 0, 3);
      run("illegal", 7'd0, 3'd0, 1'b0, 1, 0, 1);
      run("jal", JL, 3'd0, 1'b0, 0, 0, 3);
`ifdef MC_MEM_READY_EN
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         op = RT; Zero = 1'b1;
         check($sformatf("fetch_wait%0d", i), model(RT, 3'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0));
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      run("after_wait", RT, 3'd7, 1'b0, 2, 0, 3);
`endif
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 7))
            0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = JL; 5: o = BQ; 6: o = 7'd0;
            default: begin
               o = 7'($urandom);
               while (legal(o)) o = 7'($urandom);
            end
         endcase
         run($sformatf("rnd%0d op%b", n, o), o, f3s[$urandom_range(0, 3)], 1'($urandom), 2, 0, cycles(o) - 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared multicycle RV32I datapath: one memory, one ALU, and an instruction register (IR) reused across cycles.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Replaces the single-cycle control path; the ALU decode is reused unchanged.
- Sits beside the datapath and takes op/funct fields from the IR plus the ALU Zero flag.

Parameters:
- none (encodings come from the package)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  IR[6:0], stable from the cycle after FETCH
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU result == 0
- mem_ready  in  1  memory handshake; present only with MC_MEM_READY_EN
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg
- ALUSrcB  out  2  00 = rs2 reg, 01 = ImmExt, 10 = constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  immediate format select
- ALUControl  out  3  ALU operation
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- instr_retire  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- State register: asynchronous reset to FETCH. While reset=1, PCWrite, IRWrite, RegWrite, MemWrite, illegal_op and instr_retire are forced to 0; all other outputs take their FETCH values.
- Transitions:
  - FETCH -> DECODE
  - DECODE: op 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH with illegal_op=1 for that cycle
  - MEMADR: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE
  - MEMREAD -> MEMWB -> FETCH
  - MEMWRITE -> FETCH
  - EXECUTER -> ALUWB; EXECUTEI -> ALUWB; JAL -> ALUWB; ALUWB -> FETCH
  - BEQ -> FETCH
- Outputs per state (any signal not listed is 0; ALUOp is internal):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00
  - MEMREAD: ResultSrc=00, AdrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - ALUWB: ResultSrc=00, RegWrite=1
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
- PCWrite = (Branch & Zero) | PCUpdate, combinational from the same cycle's Zero.
- ImmSrc, combinational from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
- ALUControl comes from the aludec instance (inputs op[5], funct3, funct7b5, ALUOp):
  - ALUOp 00 -> add 000; 01 -> sub 001; 10 -> decoded from funct
  - R-type with funct7b5=1 and funct3=000 -> sub
- instr_retire=1 in MEMWB, MEMWRITE, ALUWB and BEQ.
- Cycle counts: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
- Reset asserted mid-instruction: the state returns to FETCH immediately, with no partial writes.

Optional Feature:
- Macro: MC_MEM_READY_EN.
- Defined: the mem_ready port exists.
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - In FETCH, IRWrite and PCUpdate are asserted only in the cycle mem_ready=1.
  - MemWrite stays asserted throughout MEMWRITE; the write completes in the mem_ready=1 cycle.
  - instr_retire in MEMWRITE pulses only in the mem_ready=1 cycle.
- Undefined: no mem_ready port; behaviour is exactly as above with mem_ready treated as constant 1.

Decomposition:
- Package riscv_mc_pkg contains:
  - state enum (FETCH ... JAL, 4-bit)
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
  - ALUOp encodings
  - ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
- Sub-modules:
  - Reuse the existing aludec instance.
  - One new sub-module, mc_fsm (state register, next-state logic, Moore outputs). The top level adds PCWrite, ImmSrc and aludec.

Test Plan:
- Reset asserted in MEMREAD of a lw -> the next sampled state is FETCH; all write enables are 0 during reset; the first cycle after release has IRWrite=1 and PCWrite=1.
- op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 only in cycle 5, with ResultSrc=01.
  - AdrSrc=1 in cycle 4.
  - instr_retire in cycle 5.
- op=1100011 with Zero=1 -> PCWrite=1 and ALUControl=001 in the BEQ cycle. Repeat with Zero=0 -> PCWrite=0. Both take 3 cycles, with ImmSrc=10.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER, then RegWrite=1 with ResultSrc=00. Total 4 cycles.
- op=0000000 -> illegal_op=1 in the DECODE cycle, then FETCH; RegWrite, MemWrite and PCWrite are never asserted after FETCH.
- MC_MEM_READY_EN with mem_ready=0 for 3 cycles in FETCH -> state holds and IRWrite=PCWrite=0. On the 4th cycle, with mem_ready=1, IRWrite=PCWrite=1 and the next state is DECODE.
